// File: rtl/syscall_display_pkg.sv
// Shared constants for the syscall display: digit geometry, segment codes and the hex glyph table.
package syscall_display_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 3;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} glyphs for one hex nibble.
    function automatic logic [6:0] hex_code(input logic [3:0] nibble);
        logic [6:0] code;
        code = 7'h7F;
        case (nibble)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            4'hF: code = 7'h0E;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/syscall_display_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
    import syscall_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_code(nibble);
    end

endmodule

// File: rtl/syscall_display.sv
// Buffers syscall output values in a FIFO, holds each on screen for a minimum time,
// and scans the current value as 8 hex digits onto an active-low 7-segment display.
module syscall_display
    import syscall_display_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int SCAN_DIV    = 100000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     syscallValid,
    input  logic [31:0]              syscallData,
    input  logic                     halted,
    output logic [7:0]               seg,
    output logic [7:0]               an,
    output logic [31:0]              shownValue,
    output logic [$clog2(DEPTH):0]   fifoCount,
    output logic                     overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [31:0]         mem [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic                loaded;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [DIGIT_W-1:0]  digit;

    logic full;
    logic empty;
    logic hold_done;
    logic pop;
    logic push;
    logic [3:0] nibble;
    logic [6:0] glyph;

    assign full      = (fifoCount == CNT_FULL);
    assign empty     = (fifoCount == '0);
    assign hold_done = (hold_cnt == HOLD_LAST);
    // Pop is decided from registered state only, so a push is never shown in its own cycle.
    assign pop       = !empty && (!loaded || hold_done);
    assign push      = syscallValid && (!full || pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            fifoCount  <= '0;
            overflow   <= 1'b0;
            shownValue <= '0;
            loaded     <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head       <= head + PTR_W'(1);
                shownValue <= mem[head];
                loaded     <= 1'b1;
                hold_cnt   <= '0;
            end else if (loaded && !hold_done) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
            if (syscallValid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[tail] <= syscallData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            digit    <= digit + DIGIT_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    assign nibble = shownValue[{digit, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .nibble (nibble),
        .seg    (glyph)
    );

    always_comb begin
        seg      = SEG_BLANK;
        seg[6:0] = glyph;
        seg[7]   = ~(halted && (digit == '0));
        an       = ~(NUM_DIGITS'(1) << digit);
    end

endmodule

// File: tb/tb_syscall_display.sv
// Randomised self-checking bench for syscall_display against a queue-based behavioural model.
module tb_syscall_display;

    localparam int DEPTH = 4;
    localparam int HOLD  = 16;
    localparam int SCAN  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        syscallValid = 1'b0;
    logic [31:0] syscallData = '0;
    logic        halted = 1'b0;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic [31:0] shownValue;
    logic [2:0]  fifoCount;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] q[$];
    logic [31:0] m_shown;
    bit          m_loaded;
    int          m_since;
    bit          m_ovf;
    int          m_cycles;

    logic [7:0] glyphs [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                                 8'h00, 8'h10, 8'h08, 8'h03, 8'h46, 8'h21, 8'h06, 8'h0E};

    syscall_display #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .SCAN_DIV(SCAN)) dut (
        .clock        (clock),
        .reset        (reset),
        .syscallValid (syscallValid),
        .syscallData  (syscallData),
        .halted       (halted),
        .seg          (seg),
        .an           (an),
        .shownValue   (shownValue),
        .fifoCount    (fifoCount),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_shown  = '0;
        m_loaded = 1'b0;
        m_since  = 0;
        m_ovf    = 1'b0;
        m_cycles = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [31:0] d);
        bit can_pop;
        int size_before;
        size_before = q.size();
        can_pop = (size_before > 0) && (!m_loaded || m_since >= HOLD - 1);
        if (can_pop) begin
            m_shown  = q.pop_front();
            m_loaded = 1'b1;
            m_since  = 0;
        end else if (m_loaded) begin
            m_since++;
        end
        if (v) begin
            if (size_before < DEPTH || can_pop) q.push_back(d);
            else m_ovf = 1'b1;
        end
        m_cycles++;
    endfunction

    function automatic int m_digit();
        return (m_cycles / SCAN) % 8;
    endfunction

    function automatic logic [7:0] exp_seg();
        logic [7:0] s;
        int dg;
        dg = m_digit();
        s = glyphs[(m_shown >> (4 * dg)) & 32'hF];
        s[7] = !(halted && dg == 0);
        return s;
    endfunction

    task automatic check_all();
        logic [7:0] exp_an;
        exp_an = ~(8'd1 << m_digit());
        chk("an", {24'd0, an}, {24'd0, exp_an});
        chk("seg", {24'd0, seg}, {24'd0, exp_seg()});
        chk("shown", shownValue, m_shown);
        chk("count", {29'd0, fifoCount}, q.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    // Inputs change on the falling edge; outputs are checked on the following falling edge.
    task automatic tick(input bit v, input logic [31:0] d);
        syscallValid = v;
        syscallData  = d;
        @(posedge clock);
        if (reset) model_reset();
        else model_step(v, d);
        @(negedge clock);
        check_all();
        syscallValid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        tick(1'b0, '0);
        tick(1'b0, '0);
        reset = 1'b0;
    endtask

    initial begin
        int last_t;
        int t;
        bit found;
        logic [31:0] prev;

        // Reset state
        model_reset();
        @(negedge clock);
        do_reset();
        chk("rst_an", {24'd0, an}, 32'hFE);
        chk("rst_seg", {24'd0, seg}, 32'hC0);
        chk("rst_shown", shownValue, 32'h0);

        // Single value, then glyphs for digits 0 and 3
        tick(1'b1, 32'h0000ABCD);
        chk("single_before", shownValue, 32'h0);
        tick(1'b0, '0);
        chk("single_after", shownValue, 32'h0000ABCD);
        chk("single_count", {29'd0, fifoCount}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            tick(1'b0, '0);
            if (m_digit() == 0) begin
                chk("glyph_d", {24'd0, seg}, 32'hA1);
                found = 1'b1;
            end
        end
        chk("glyph_d_reached", {31'd0, found}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            tick(1'b0, '0);
            if (m_digit() == 3) begin
                chk("glyph_A", {24'd0, seg}, 32'h88);
                found = 1'b1;
            end
        end
        chk("glyph_A_reached", {31'd0, found}, 32'd1);

        // Burst of six: one loaded, four queued, one dropped, then paced by the hold time
        do_reset();
        for (int i = 1; i <= 6; i++) tick(1'b1, i);
        chk("burst_ovf", {31'd0, overflow}, 32'd1);
        chk("burst_count", {29'd0, fifoCount}, 32'd4);
        chk("burst_first", shownValue, 32'd1);
        last_t = -1;
        t = 0;
        prev = shownValue;
        for (int i = 0; i < 90; i++) begin
            tick(1'b0, '0);
            t++;
            if (shownValue != prev) begin
                if (last_t >= 0) chk("burst_interval", t - last_t, 32'd16);
                last_t = t;
                prev = shownValue;
            end
        end
        chk("burst_last", shownValue, 32'd5);

        // Push coinciding with the hold-expiry pop while full
        do_reset();
        for (int i = 10; i <= 14; i++) tick(1'b1, i);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (q.size() == DEPTH && m_loaded && m_since >= HOLD - 1) found = 1'b1;
            else tick(1'b0, '0);
        end
        chk("coinc_reached", {31'd0, found}, 32'd1);
        tick(1'b1, 32'd15);
        chk("coinc_count", {29'd0, fifoCount}, 32'd4);
        chk("coinc_ovf", {31'd0, overflow}, 32'd0);
        chk("coinc_shown", shownValue, 32'd11);

        // Free-run scanning with halted set
        halted = 1'b1;
        for (int i = 0; i < 32; i++) tick(1'b0, '0);
        halted = 1'b0;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) halted = $urandom_range(0, 1);
            tick($urandom_range(0, 5) == 0, $urandom);
        end

        // Reset mid-operation with three entries queued and digit 5 selected
        halted = 1'b0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (q.size() == 3 && m_digit() == 5) found = 1'b1;
            else tick(q.size() < 3, $urandom);
        end
        chk("mid_reached", {31'd0, found}, 32'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("mid_an", {24'd0, an}, 32'hFE);
        chk("mid_seg", {24'd0, seg}, 32'hC0);
        chk("mid_shown", shownValue, 32'h0);
        chk("mid_count", {29'd0, fifoCount}, 32'd0);
        chk("mid_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clock);
        tick(1'b1, 32'hDEADBEEF);
        reset = 1'b0;
        tick(1'b1, 32'h12345678);
        chk("post_before", shownValue, 32'h0);
        tick(1'b0, '0);
        chk("post_shown", shownValue, 32'h12345678);
        chk("post_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 20; i++) tick(1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
